// File: rtl/closest_hit_reducer.sv
// Reduces a batch of per-triangle intersection results to the closest accepted hit.
// Accepts one beat per cycle, with restart, timeout and stray-beat (overflow) reporting.
module closest_hit_reducer #(
  parameter int unsigned        CNT_W   = 32,
  parameter logic signed [31:0] MIN_T   = 32'sd0,
  parameter logic [31:0]        T_INIT  = 32'h7fff_ffff,
  parameter int unsigned        TIMEOUT = 1024
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_tri_cnt,
  input  logic             i_valid,
  input  logic             i_result,
  input  logic [31:0]      i_t,
  input  logic             i_ack,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_hit,
  output logic [31:0]      o_t,
  output logic [CNT_W-1:0] o_tri_index,
  output logic             o_timeout,
  output logic             o_overflow
);

  localparam int unsigned     TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_nx;
  logic             busy_nx;
  logic             done_nx;

  logic [CNT_W-1:0] tri_cnt_q;
  logic [CNT_W-1:0] rcv_cnt_q;
  logic [TO_W-1:0]  idle_cnt_q;

  logic             in_collect;
  logic             beat_acc;
  logic             last_beat;
  logic             to_fire;
  logic             better_hit;
  logic             stray_beat;

  // Beat qualification; a same-cycle i_start always wins over the beat.
  assign in_collect = (state_q == S_COLLECT);
  assign beat_acc   = in_collect && i_valid && !i_start;
  assign last_beat  = beat_acc && (rcv_cnt_q == CNT_W'(tri_cnt_q - CNT_W'(1)));
  assign to_fire    = TO_EN && in_collect && !i_valid && !i_start && (idle_cnt_q == TO_LAST);
  assign better_hit = beat_acc && i_result &&
                      ($signed(i_t) >= MIN_T) &&
                      ($signed(i_t) < $signed(o_t));
  assign stray_beat = i_valid && !i_start && !in_collect;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    if (i_start) begin
      state_nx = (i_tri_cnt == '0) ? S_DONE : S_COLLECT;
    end else begin
      case (state_q)
        S_IDLE:    state_nx = S_IDLE;
        S_COLLECT: if (last_beat || to_fire) state_nx = S_DONE;
        S_DONE:    if (i_ack) state_nx = S_IDLE;
        default:   state_nx = S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the next state, then registered
  always_comb begin
    busy_nx = 1'b0;
    done_nx = 1'b0;
    case (state_nx)
      S_COLLECT: busy_nx = 1'b1;
      S_DONE:    done_nx = 1'b1;
      default: begin
        busy_nx = 1'b0;
        done_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_busy <= busy_nx;
      o_done <= done_nx;
    end
  end

  // Running minimum, beat/idle counters and sticky flags
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      tri_cnt_q   <= '0;
      rcv_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      o_hit       <= 1'b0;
      o_t         <= T_INIT;
      o_tri_index <= '0;
      o_timeout   <= 1'b0;
      o_overflow  <= 1'b0;
    end else if (i_start) begin
      tri_cnt_q   <= i_tri_cnt;
      rcv_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      o_hit       <= 1'b0;
      o_t         <= T_INIT;
      o_tri_index <= '0;
      o_timeout   <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (stray_beat) begin
        o_overflow <= 1'b1;
      end
      if (beat_acc) begin
        rcv_cnt_q <= rcv_cnt_q + CNT_W'(1);
      end
      if (better_hit) begin
        o_t         <= i_t;
        o_tri_index <= rcv_cnt_q;
        o_hit       <= 1'b1;
      end
      // Idle counter saturates rather than wrapping
      if (i_valid) begin
        idle_cnt_q <= '0;
      end else if (in_collect && (idle_cnt_q != '1)) begin
        idle_cnt_q <= idle_cnt_q + TO_W'(1);
      end
      if (to_fire) begin
        o_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_closest_hit_reducer.sv
// Self-checking bench for closest_hit_reducer: vector table plus hand-written corner sequences.
module tb_closest_hit_reducer;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TMO     = 8;
  localparam logic [31:0] T_INIT  = 32'h7fff_ffff;

  logic             i_clk = 1'b0;
  logic             i_rstn;
  logic             i_start;
  logic [CNT_W-1:0] i_tri_cnt;
  logic             i_valid;
  logic             i_result;
  logic [31:0]      i_t;
  logic             i_ack;
  logic             o_busy;
  logic             o_done;
  logic             o_hit;
  logic [31:0]      o_t;
  logic [CNT_W-1:0] o_tri_index;
  logic             o_timeout;
  logic             o_overflow;

  closest_hit_reducer #(
    .CNT_W  (CNT_W),
    .MIN_T  (32'sd0),
    .T_INIT (T_INIT),
    .TIMEOUT(TMO)
  ) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_start    (i_start),
    .i_tri_cnt  (i_tri_cnt),
    .i_valid    (i_valid),
    .i_result   (i_result),
    .i_t        (i_t),
    .i_ack      (i_ack),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_hit      (o_hit),
    .o_t        (o_t),
    .o_tri_index(o_tri_index),
    .o_timeout  (o_timeout),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        hit;
    logic [31:0] t;
    logic [31:0] idx;
    logic        tmo;
  } exp_t;

  typedef struct packed {
    logic [31:0]      cnt;
    logic [3:0][31:0] t;
    logic [3:0]       res;
    exp_t             exp;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic [31:0] cnt, input logic [31:0] t0, input logic [31:0] t1,
                              input logic [31:0] t2, input logic [31:0] t3, input logic [3:0] res,
                              input logic e_hit, input logic [31:0] e_t, input logic [31:0] e_idx);
    vec_t v;
    v.cnt  = cnt;
    v.t[0] = t0;
    v.t[1] = t1;
    v.t[2] = t2;
    v.t[3] = t3;
    v.res  = res;
    v.exp  = '{hit: e_hit, t: e_t, idx: e_idx, tmo: 1'b0};
    return v;
  endfunction

  task automatic cyc();
    @(negedge i_clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_sb: got empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hit"}, 32'(o_hit), 32'(e.hit));
      chk({tag, "_t"}, o_t, e.t);
      chk({tag, "_idx"}, o_tri_index, e.idx);
      chk({tag, "_tmo"}, 32'(o_timeout), 32'(e.tmo));
    end
  endtask

  task automatic beat(input logic res, input logic [31:0] t);
    i_valid  = 1'b1;
    i_result = res;
    i_t      = t;
    cyc();
    i_valid  = 1'b0;
    i_result = 1'b0;
  endtask

  task automatic start(input logic [31:0] cnt);
    i_start   = 1'b1;
    i_tri_cnt = cnt;
    cyc();
    i_start   = 1'b0;
  endtask

  task automatic ack();
    i_ack = 1'b1;
    cyc();
    i_ack = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = mk(3, 32'h30000, 32'h10000, 32'h20000, 32'h0, 4'b0111, 1'b1, 32'h10000, 1);
    vecs[1] = mk(4, 32'h5, 32'h6, 32'h7, 32'h8, 4'b0000, 1'b0, T_INIT, 0);
    vecs[2] = mk(3, 32'h8000, 32'h40000, 32'h8000, 32'h0, 4'b0111, 1'b1, 32'h8000, 0);
    vecs[3] = mk(4, 32'hffff_0000, 32'h8000, 32'h20000, 32'h8000, 4'b1111, 1'b1, 32'h8000, 1);
    vecs[4] = mk(2, T_INIT, T_INIT, 32'h0, 32'h0, 4'b0011, 1'b0, T_INIT, 0);
    vecs[5] = mk(2, 32'h10000, 32'h0, 32'h0, 32'h0, 4'b0011, 1'b1, 32'h0, 1);
    vecs[6] = mk(3, 32'h10000, 32'h5000, 32'h20000, 32'h0, 4'b0101, 1'b1, 32'h10000, 0);
    vecs[7] = mk(0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0, T_INIT, 0);

    i_rstn = 1'b0; i_start = 1'b0; i_tri_cnt = '0; i_valid = 1'b0;
    i_result = 1'b0; i_t = '0; i_ack = 1'b0;
    repeat (3) cyc();
    i_rstn = 1'b1;
    cyc();

    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_hit", 32'(o_hit), 0);
    chk("rst_t", o_t, T_INIT);
    chk("rst_idx", o_tri_index, 0);
    chk("rst_tmo", 32'(o_timeout), 0);
    chk("rst_ovf", 32'(o_overflow), 0);

    // Table-driven batches: o_done must rise the cycle after the last beat and hold until ack
    for (int k = 0; k < 8; k++) begin
      start(vecs[k].cnt);
      for (int b = 0; b < int'(vecs[k].cnt); b++) begin
        chk($sformatf("v%0d_busy%0d", k, b), 32'(o_busy), 1);
        beat(vecs[k].res[b], vecs[k].t[b]);
      end
      sb.push_back(vecs[k].exp);
      chk($sformatf("v%0d_done_lat", k), 32'(o_done), 1);
      check_result($sformatf("v%0d", k));
      repeat (2) cyc();
      chk($sformatf("v%0d_done_hold", k), 32'(o_done), 1);
      chk($sformatf("v%0d_t_hold", k), o_t, vecs[k].exp.t);
      ack();
      chk($sformatf("v%0d_released", k), 32'(o_done), 0);
      chk($sformatf("v%0d_idle_busy", k), 32'(o_busy), 0);
    end

    // Stray beats in IDLE and DONE raise overflow; start wins over a same-cycle ack
    beat(1'b1, 32'h100);
    chk("ovf_idle", 32'(o_overflow), 1);
    start(0);
    chk("ovf_cleared", 32'(o_overflow), 0);
    chk("cnt0_done", 32'(o_done), 1);
    sb.push_back('{hit: 1'b0, t: T_INIT, idx: 32'd0, tmo: 1'b0});
    check_result("cnt0");
    beat(1'b1, 32'h100);
    chk("ovf_done", 32'(o_overflow), 1);
    chk("ovf_done_held", 32'(o_done), 1);
    chk("ovf_t_kept", o_t, T_INIT);
    chk("ovf_hit_kept", 32'(o_hit), 0);
    i_ack = 1'b1;
    start(1);
    i_ack = 1'b0;
    chk("start_over_ack_busy", 32'(o_busy), 1);
    chk("start_over_ack_done", 32'(o_done), 0);
    chk("start_over_ack_ovf", 32'(o_overflow), 0);
    beat(1'b1, 32'h30000);
    sb.push_back('{hit: 1'b1, t: 32'h30000, idx: 32'd0, tmo: 1'b0});
    chk("one_done", 32'(o_done), 1);
    check_result("one");
    ack();

    // Timeout after TMO silent cycles keeps the partial minimum
    begin
      int n;
      start(5);
      beat(1'b1, 32'h30000);
      beat(1'b1, 32'h10000);
      n = 0;
      while (!o_done && n < 40) begin
        cyc();
        n++;
      end
      chk("tmo_latency", 32'(n), 32'(TMO));
      sb.push_back('{hit: 1'b1, t: 32'h10000, idx: 32'd1, tmo: 1'b1});
      check_result("tmo");
      ack();
      chk("tmo_released", 32'(o_done), 0);
    end

    // Restart mid-batch with a same-cycle beat that must be dropped; ack in COLLECT ignored
    start(3);
    i_ack = 1'b1;
    beat(1'b1, 32'h10000);
    i_ack = 1'b0;
    i_valid = 1'b1; i_result = 1'b1; i_t = 32'h100;
    start(2);
    i_valid = 1'b0; i_result = 1'b0;
    chk("rs_busy", 32'(o_busy), 1);
    chk("rs_t_cleared", o_t, T_INIT);
    beat(1'b1, 32'h20000);
    chk("rs_not_done", 32'(o_done), 0);
    beat(1'b1, 32'h30000);
    sb.push_back('{hit: 1'b1, t: 32'h20000, idx: 32'd0, tmo: 1'b0});
    chk("rs_done", 32'(o_done), 1);
    check_result("rs");
    ack();

    // Reset mid-batch discards everything
    start(4);
    beat(1'b1, 32'h10000);
    i_rstn = 1'b0;
    cyc();
    i_rstn = 1'b1;
    chk("mr_busy", 32'(o_busy), 0);
    chk("mr_done", 32'(o_done), 0);
    chk("mr_hit", 32'(o_hit), 0);
    chk("mr_t", o_t, T_INIT);
    cyc();
    chk("mr_stays_idle", 32'(o_busy), 0);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: got %0d leftover entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
